io_port_module: RTL and testbench

IO_PORT_MODULE -- requirements
Module: io_port_module

---
 rtl/io_port_module.sv | 131 +++++++++++++
 tb/tb_io_port_module.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_module.sv
// rtl/io_port_module.sv - memory-mapped I/O port block with synchronized inputs, change flags and counter
module io_port_module #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] in_port0,
    input  logic [31:0] in_port1,
    output logic [4:0]  out_port0,
    output logic [4:0]  out_port1,
    output logic [4:0]  out_port2,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        irq
);

    localparam logic [2:0] ARM_EDGES = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][31:0] sync0_q;
    logic [SYNC_STAGES-1:0][31:0] sync1_q;
    logic [31:0] in_sync0;
    logic [31:0] in_sync1;
    logic [31:0] prev0;
    logic [31:0] prev1;
    logic [2:0]  arm_cnt;
    logic        armed;
    logic        chg0;
    logic        chg1;
    logic [15:0] cnt0;
    logic        ev0;
    logic        ev1;

    logic        wr_p0;
    logic        wr_p1;
    logic        wr_p2;
    logic        wr_clr;
    logic        clr_chg0;
    logic        clr_chg1;
    logic        clr_cnt0;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign in_sync0 = sync0_q[SYNC_STAGES-1];
    assign in_sync1 = sync1_q[SYNC_STAGES-1];

    // Arming holds off change detection until the synchronizer and previous-sample
    // registers have filled with real input values after reset.
    assign armed = (arm_cnt == ARM_EDGES);
    assign ev0   = armed && (in_sync0 != prev0);
    assign ev1   = armed && (in_sync1 != prev1);

    assign wr_p0  = we && (addr[7:2] == 6'h20);
    assign wr_p1  = we && (addr[7:2] == 6'h21);
    assign wr_p2  = we && (addr[7:2] == 6'h22);
    assign wr_clr = we && (addr[7:2] == 6'h23);

    assign clr_chg0 = wr_clr && wdata[0];
    assign clr_chg1 = wr_clr && wdata[1];
    assign clr_cnt0 = wr_clr && wdata[2];

    always_comb begin
        rd_mux = 32'd0;
        case (addr[7:2])
            6'h30:   rd_mux = in_sync0;
            6'h31:   rd_mux = in_sync1;
            6'h32:   rd_mux = {30'd0, chg1, chg0};
            6'h33:   rd_mux = {16'd0, cnt0};
            default: rd_mux = 32'd0;
        endcase
    end

    assign irq = chg0 | chg1;

    assign unused_bits = ^{addr[31:8], addr[1:0], wdata[31:5]};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync0_q   <= '0;
            sync1_q   <= '0;
            prev0     <= 32'd0;
            prev1     <= 32'd0;
            arm_cnt   <= 3'd0;
            chg0      <= 1'b0;
            chg1      <= 1'b0;
            cnt0      <= 16'd0;
            out_port0 <= 5'd0;
            out_port1 <= 5'd0;
            out_port2 <= 5'd0;
            rdata     <= 32'd0;
            rvalid    <= 1'b0;
        end else begin
            sync0_q <= {sync0_q[SYNC_STAGES-2:0], in_port0};
            sync1_q <= {sync1_q[SYNC_STAGES-2:0], in_port1};
            prev0   <= in_sync0;
            prev1   <= in_sync1;
            if (!armed) begin
                arm_cnt <= arm_cnt + 3'd1;
            end

            // A new change event outranks a same-cycle write-1-to-clear.
            chg0 <= ev0 | (chg0 & ~clr_chg0);
            chg1 <= ev1 | (chg1 & ~clr_chg1);

            if (ev0) begin
                cnt0 <= clr_cnt0 ? 16'd1 : cnt0 + 16'd1;
            end else if (clr_cnt0) begin
                cnt0 <= 16'd0;
            end

            if (wr_p0) begin
                out_port0 <= wdata[4:0];
            end
            if (wr_p1) begin
                out_port1 <= wdata[4:0];
            end
            if (wr_p2) begin
                out_port2 <= wdata[4:0];
            end

            rvalid <= re;
            if (re) begin
                rdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_io_port_module.sv
// tb/tb_io_port_module.sv - randomized self-checking bench for io_port_module
module tb_io_port_module;

    localparam int SYNC_STAGES = 2;
    localparam int SETTLE = SYNC_STAGES + 2;

    logic        clock;
    logic        resetn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] in_port0;
    logic [31:0] in_port1;
    logic [4:0]  out_port0;
    logic [4:0]  out_port1;
    logic [4:0]  out_port2;
    logic [31:0] rdata;
    logic        rvalid;
    logic        irq;

    int checks;
    int failures;

    io_port_module #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .addr      (addr),
        .wdata     (wdata),
        .we        (we),
        .re        (re),
        .in_port0  (in_port0),
        .in_port1  (in_port1),
        .out_port0 (out_port0),
        .out_port1 (out_port1),
        .out_port2 (out_port2),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .irq       (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clock);
        we = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] rd,
                           output logic rv, output logic rv_next);
        @(negedge clock);
        addr = a; re = 1'b1;
        @(negedge clock);
        re = 1'b0;
        rd = rdata; rv = rvalid;
        @(negedge clock);
        rv_next = rvalid;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        logic rv, rvn;
        resetn = 1'b0; addr = 0; wdata = 0; we = 0; re = 0;
        in_port0 = 32'd1; in_port1 = 32'd1;
        #12;
        checks++;
        if ({out_port0, out_port1, out_port2} !== 15'd0) begin
            failures++; $display("FAIL reset_outports got=%h exp=0", {out_port0, out_port1, out_port2});
        end
        checks++;
        if ({rdata, rvalid, irq} !== 34'd0) begin
            failures++; $display("FAIL reset_rd_irq got=%h exp=0", {rdata, rvalid, irq});
        end
        @(negedge clock); resetn = 1'b1;
        idle(6);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL static_irq got=%b exp=0", irq); end
        do_read(32'h0000_00C0, rd, rv, rvn);
        checks++;
        if (rd !== 32'd1 || rv !== 1'b1 || rvn !== 1'b0) begin
            failures++; $display("FAIL read_c0 rdata=%h rvalid=%b next=%b exp 1/1/0", rd, rv, rvn);
        end
        do_read(32'h0000_00C4, rd, rv, rvn);
        checks++;
        if (rd !== 32'd1 || rv !== 1'b1 || rvn !== 1'b0) begin
            failures++; $display("FAIL read_c4 rdata=%h rvalid=%b next=%b exp 1/1/0", rd, rv, rvn);
        end
        do_read(32'h0000_00C8, rd, rv, rvn);
        checks++;
        if (rd !== 32'd0 || rv !== 1'b1) begin
            failures++; $display("FAIL read_c8_static rdata=%h rvalid=%b exp 0/1", rd, rv);
        end
        checks++;
        if (rdata !== 32'd0 || irq !== 1'b0) begin
            failures++; $display("FAIL hold_rdata got=%h irq=%b exp 0/0", rdata, irq);
        end
    endtask

    task automatic test_out_ports;
        logic [4:0] e0, e1, e2;
        logic [31:0] d;
        do_write(32'h0000_0080, 32'h15);
        do_write(32'h0000_0084, 32'h0A);
        do_write(32'h0000_0088, 32'h1F);
        checks++;
        if ({out_port0, out_port1, out_port2} !== {5'b10101, 5'b01010, 5'b11111}) begin
            failures++; $display("FAIL outports_directed got=%b_%b_%b exp=10101_01010_11111",
                                 out_port0, out_port1, out_port2);
        end
        e0 = 5'b10101; e1 = 5'b01010; e2 = 5'b11111;
        for (int i = 0; i < 12; i++) begin
            d = $urandom;
            case ($urandom_range(0, 5))
                0: begin do_write({$urandom, 8'h80} >> 8 << 8 | 32'h80, d); e0 = d[4:0]; end
                1: begin do_write(32'h0000_0084, d); e1 = d[4:0]; end
                2: begin do_write(32'h0000_0088, d); e2 = d[4:0]; end
                3: do_write(32'h0000_0090, d);
                4: do_write(32'h0000_0000 | (32'($urandom_range(0, 31)) << 2), d);
                default: do_write(32'h0000_00BC, d);
            endcase
            checks++;
            if ({out_port0, out_port1, out_port2} !== {e0, e1, e2}) begin
                failures++; $display("FAIL outports_rand%0d got=%h_%h_%h exp=%h_%h_%h",
                                     i, out_port0, out_port1, out_port2, e0, e1, e2);
            end
        end
    endtask

    task automatic test_change_latency;
        logic [31:0] rd;
        logic rv, rvn;
        do_write(32'h0000_008C, 32'h7);
        @(negedge clock); in_port0 = 32'd3;
        for (int e = 1; e <= SYNC_STAGES + 1; e++) begin
            @(negedge clock);
            checks++;
            if (irq !== (e == SYNC_STAGES + 1)) begin
                failures++; $display("FAIL latency_edge%0d irq=%b exp=%b", e, irq, e == SYNC_STAGES + 1);
            end
        end
        do_read(32'h0000_00CC, rd, rv, rvn);
        checks++;
        if (rd !== 32'd1) begin failures++; $display("FAIL cnt_after_change got=%h exp=1", rd); end
        do_read(32'h0000_00C8, rd, rv, rvn);
        checks++;
        if (rd !== 32'd1) begin failures++; $display("FAIL flags_after_change got=%h exp=1", rd); end
    endtask

    task automatic test_w1c_race;
        logic [31:0] rd;
        logic rv, rvn;
        @(negedge clock); in_port1 = in_port1 ^ 32'h8000_0001;
        @(negedge clock);
        do_write(32'h0000_008C, 32'h3);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL race_irq got=%b exp=1", irq); end
        do_read(32'h0000_00C8, rd, rv, rvn);
        checks++;
        if (rd !== 32'd2) begin failures++; $display("FAIL race_flags got=%h exp=2", rd); end
        do_write(32'h0000_008C, 32'h2);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL w1c_irq got=%b exp=0", irq); end
    endtask

    task automatic test_we_re_same_cycle;
        logic [31:0] d;
        d = $urandom;
        @(negedge clock);
        addr = 32'h0000_0080; wdata = d; we = 1'b1; re = 1'b1;
        @(negedge clock);
        we = 1'b0; re = 1'b0;
        checks++;
        if (out_port0 !== d[4:0] || rvalid !== 1'b1 || rdata !== 32'd0) begin
            failures++; $display("FAIL we_re out=%h rvalid=%b rdata=%h exp %h/1/0",
                                 out_port0, rvalid, rdata, d[4:0]);
        end
    endtask

    task automatic test_random_changes;
        logic [31:0] rd;
        logic rv, rvn;
        int c0, c1;
        logic [31:0] v;
        do_write(32'h0000_008C, 32'h7);
        c0 = 0; c1 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if ($urandom_range(0, 2) == 0) begin
                v = $urandom;
                if (v != in_port0) c0++;
                in_port0 = v;
            end
            if ($urandom_range(0, 3) == 0) begin
                v = $urandom;
                if (v != in_port1) c1++;
                in_port1 = v;
            end
        end
        idle(SETTLE);
        do_read(32'h0000_00CC, rd, rv, rvn);
        checks++;
        if (rd !== 32'(c0)) begin failures++; $display("FAIL rand_cnt got=%h exp=%h", rd, c0); end
        do_read(32'h0000_00C8, rd, rv, rvn);
        checks++;
        if (rd !== {30'd0, c1 > 0, c0 > 0}) begin
            failures++; $display("FAIL rand_flags got=%h exp=%h", rd, {30'd0, c1 > 0, c0 > 0});
        end
        do_read(32'h0000_00C4, rd, rv, rvn);
        checks++;
        if (rd !== in_port1) begin failures++; $display("FAIL rand_sync1 got=%h exp=%h", rd, in_port1); end
    endtask

    task automatic test_cnt_wrap;
        logic [31:0] rd;
        logic rv, rvn;
        int c0;
        do_write(32'h0000_008C, 32'h7);
        c0 = 0;
        while (c0 < 16'hFFFF) begin
            @(negedge clock);
            if ($urandom_range(0, 31) != 0) begin
                in_port0 = in_port0 ^ (32'($urandom) | 32'h1);
                c0++;
            end
        end
        idle(SETTLE);
        do_read(32'h0000_00CC, rd, rv, rvn);
        checks++;
        if (rd !== 32'h0000_FFFF) begin failures++; $display("FAIL cnt_full got=%h exp=0000ffff", rd); end
        @(negedge clock); in_port0 = ~in_port0;
        idle(SETTLE);
        do_read(32'h0000_00CC, rd, rv, rvn);
        checks++;
        if (rd !== 32'd0) begin failures++; $display("FAIL cnt_wrap got=%h exp=0", rd); end
        @(negedge clock); in_port0 = ~in_port0;
        idle(SETTLE);
        @(negedge clock); in_port0 = ~in_port0;
        @(negedge clock);
        do_write(32'h0000_008C, 32'h4);
        idle(2);
        do_read(32'h0000_00CC, rd, rv, rvn);
        checks++;
        if (rd !== 32'd1) begin failures++; $display("FAIL cnt_clear_race got=%h exp=1", rd); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        logic rv, rvn;
        do_write(32'h0000_0084, 32'h0A);
        do_read(32'h0000_00C0, rd, rv, rvn);
        @(negedge clock); in_port1 = ~in_port1;
        idle(SETTLE);
        checks++;
        if (out_port1 !== 5'h0A || irq !== 1'b1 || rdata === 32'd0) begin
            failures++; $display("FAIL pre_reset out1=%h irq=%b rdata=%h exp 0a/1/nonzero",
                                 out_port1, irq, rdata);
        end
        @(posedge clock);
        addr = 32'h0000_0080; wdata = 32'h1F; we = 1'b1;
        #3 resetn = 1'b0;
        #1;
        checks++;
        if ({out_port0, out_port1, out_port2, rdata, rvalid, irq} !== 49'd0) begin
            failures++; $display("FAIL async_reset got=%h exp=0",
                                 {out_port0, out_port1, out_port2, rdata, rvalid, irq});
        end
        idle(2);
        we = 1'b0; resetn = 1'b1;
        idle(2);
        checks++;
        if (out_port0 !== 5'd0) begin failures++; $display("FAIL abandoned_store got=%h exp=0", out_port0); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset;
        test_out_ports;
        test_change_latency;
        test_w1c_race;
        test_we_re_same_cycle;
        test_random_changes;
        test_cnt_wrap;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
